qspi_bus_arbiter: RTL

//  Two-master arbiter sharing the single QSPI SRAM bus port (REQ/WRITE/ADDR/WDATA/RDATA/RDY).

---
 rtl/qspi_bus_arbiter_if.sv | 31 +++
 rtl/qspi_bus_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/qspi_bus_arbiter_if.sv
// Shared QSPI SRAM port: two master request channels plus the single bus towards the SRAM.
interface qspi_bus_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 8
) ();
    logic [1:0]          m_req;
    logic [1:0]          m_write;
    logic [1:0][AW-1:0]  m_addr;
    logic [1:0][DW-1:0]  m_wdata;
    logic [1:0][DW-1:0]  m_rdata;
    logic [1:0]          m_rdy;
    logic                bus_req;
    logic                bus_write;
    logic [AW-1:0]       bus_addr;
    logic [DW-1:0]       bus_wdata;
    logic [DW-1:0]       bus_rdata;
    logic                bus_rdy;
    logic [1:0]          gnt;

    // Arbiter side
    modport slave (
        input  m_req, m_write, m_addr, m_wdata, bus_rdata, bus_rdy,
        output m_rdata, m_rdy, bus_req, bus_write, bus_addr, bus_wdata, gnt
    );

    // Environment side: masters and the SRAM
    modport master (
        output m_req, m_write, m_addr, m_wdata, bus_rdata, bus_rdy,
        input  m_rdata, m_rdy, bus_req, bus_write, bus_addr, bus_wdata, gnt
    );
endinterface

// File: rtl/qspi_bus_arbiter.sv
// Two-master arbiter for the QSPI SRAM port: one transaction in flight, round-robin or fixed priority.
module qspi_bus_arbiter #(
    parameter int DW         = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    qspi_bus_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic               owner;
    logic               last;
    logic [1:0][DW-1:0] held;
    logic               winner;
    logic               done;
    logic [1:0]         rdy;

    // Tie goes to the master not served last unless M0 is fixed-priority
    always_comb begin
        winner = 1'b0;
        if (bus.m_req == 2'b11)
            winner = FIXED_PRIO ? 1'b0 : ~last;
        else
            winner = bus.m_req[1];
    end

    assign done = (state == BUSY) && bus.bus_rdy;

    // Completion and read data are combinational so the master sees them in the BUS_RDY cycle
    always_comb begin
        rdy = '0;
        if (done)
            rdy[owner] = 1'b1;
        for (int unsigned i = 0; i < 2; i++)
            bus.m_rdata[i] = rdy[i] ? bus.bus_rdata : held[i];
        bus.m_rdy = rdy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last          <= 1'b1;
            held          <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_write <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.gnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.m_req) begin
                        owner         <= winner;
                        bus.gnt       <= winner ? 2'b10 : 2'b01;
                        bus.bus_req   <= 1'b1;
                        bus.bus_write <= bus.m_write[winner];
                        bus.bus_addr  <= bus.m_addr[winner];
                        bus.bus_wdata <= bus.m_wdata[winner];
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.bus_rdy) begin
                        held[owner] <= bus.bus_rdata;
                        last        <= owner;
                        bus.gnt     <= '0;
                        bus.bus_req <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
